// File: rtl/ws2812b_pixel_encoder_if.sv
// ws2812b_pixel_encoder_if: valid/ready pixel channel feeding the WS2812B encoder
interface ws2812b_pixel_encoder_if;
    logic        pix_valid;
    logic [23:0] pix_data;
    logic        pix_ready;
    modport master (output pix_valid, pix_data, input pix_ready);
    modport slave (input pix_valid, pix_data, output pix_ready);
endinterface

// File: rtl/ws2812b_pixel_encoder.sv
// ws2812b_pixel_encoder: serialises 24-bit GRB pixels into a WS2812B single-wire waveform
module ws2812b_pixel_encoder #(
    parameter int CNT_W = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    ws2812b_pixel_encoder_if.slave   pix,
    input  logic                     latch_req,
    input  logic [CNT_W-1:0]         t0h_cycles,
    input  logic [CNT_W-1:0]         t1h_cycles,
    input  logic [CNT_W-1:0]         tbit_cycles,
    input  logic [CNT_W-1:0]         tlatch_cycles,
    output logic                     dout,
    output logic                     busy,
    output logic                     latch_done
);
    typedef enum logic [1:0] {IDLE, HIGH, LOW, LATCH} state_t;
    localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

    state_t           state_q;
    logic [23:0]      buf_q, sh_q;
    logic             buf_full_q, latch_pend_q, dout_q, latch_done_q;
    logic [4:0]       bit_q;
    logic [CNT_W-1:0] cnt_q, low_q;
    logic             accept_d, start_d, reload_d, next_bit_d;
    logic [CNT_W-1:0] th_d, hi_d, lo_d, lat_d;

    assign pix.pix_ready = !buf_full_q && !latch_pend_q;
    assign accept_d      = pix.pix_valid && pix.pix_ready;
    assign dout          = dout_q;
    assign latch_done    = latch_done_q;
    assign busy          = state_q != IDLE || buf_full_q || latch_pend_q;

    // timing snapshot for the bit about to start, taken from the live timing inputs
    always_comb begin
        start_d    = (state_q == IDLE && buf_full_q) ||
                     (state_q == LOW && cnt_q == '0 && (bit_q != 5'd23 || buf_full_q));
        reload_d   = state_q == IDLE || bit_q == 5'd23;
        next_bit_d = reload_d ? buf_q[23] : sh_q[22];
        th_d       = next_bit_d ? t1h_cycles : t0h_cycles;
        hi_d       = th_d == '0 ? ONE : th_d;
        lo_d       = tbit_cycles > th_d ? tbit_cycles - th_d : ONE;
        lat_d      = tlatch_cycles == '0 ? ONE : tlatch_cycles;
    end

    // buffer, latch request and bit-timing FSM with registered dout/latch_done
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            buf_q        <= '0;
            sh_q         <= '0;
            buf_full_q   <= 1'b0;
            latch_pend_q <= 1'b0;
            dout_q       <= 1'b0;
            latch_done_q <= 1'b0;
            bit_q        <= '0;
            cnt_q        <= '0;
            low_q        <= '0;
        end else begin
            latch_done_q <= 1'b0;
            if (accept_d) begin
                buf_q      <= pix.pix_data;
                buf_full_q <= 1'b1;
            end
            if (latch_req && !latch_pend_q && state_q != LATCH) latch_pend_q <= 1'b1;
            if (start_d) begin
                state_q <= HIGH;
                dout_q  <= 1'b1;
                cnt_q   <= hi_d - ONE;
                low_q   <= lo_d;
                if (reload_d) begin
                    sh_q       <= buf_q;
                    buf_full_q <= 1'b0;
                    bit_q      <= '0;
                end else begin
                    sh_q  <= {sh_q[22:0], 1'b0};
                    bit_q <= bit_q + 5'd1;
                end
            end else if (cnt_q != '0) begin
                cnt_q <= cnt_q - ONE;
            end else begin
                case (state_q)
                    IDLE, LOW: begin
                        state_q <= latch_pend_q ? LATCH : IDLE;
                        cnt_q   <= latch_pend_q ? lat_d - ONE : '0;
                        dout_q  <= 1'b0;
                    end
                    HIGH: begin
                        state_q <= LOW;
                        dout_q  <= 1'b0;
                        cnt_q   <= low_q - ONE;
                    end
                    default: begin
                        state_q      <= IDLE;
                        latch_done_q <= 1'b1;
                        latch_pend_q <= 1'b0;
                    end
                endcase
            end
        end
    end
endmodule

// File: tb/tb_ws2812b_pixel_encoder.sv
// tb_ws2812b_pixel_encoder: table, directed and random checks of the WS2812B encoder
module tb_ws2812b_pixel_encoder;
    localparam int CNT_W = 16;
    localparam int LOGN  = 65536;

    logic clk = 1'b0, reset = 1'b1, latch_req = 1'b0;
    logic [CNT_W-1:0] t0h = 26, t1h = 51, tbit = 80, tlat = 100;
    logic dout, busy, latch_done;
    int cyc = 0;
    int n_chk = 0, n_fail = 0;
    bit lg_dout [LOGN];
    bit lg_busy [LOGN];
    bit lg_rdy  [LOGN];
    bit lg_ld   [LOGN];
    bit exp_q [$];

    ws2812b_pixel_encoder_if pif();

    ws2812b_pixel_encoder #(.CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset), .pix(pif), .latch_req(latch_req),
        .t0h_cycles(t0h), .t1h_cycles(t1h), .tbit_cycles(tbit), .tlatch_cycles(tlat),
        .dout(dout), .busy(busy), .latch_done(latch_done)
    );

    always #5 clk = ~clk;

    // cycle counter: value seen after posedge N is N
    always @(posedge clk) cyc <= cyc + 1;

    // log outputs mid-cycle, indexed by the edge that produced them
    always @(negedge clk) begin
        if (cyc < LOGN) begin
            lg_dout[cyc] = dout;
            lg_busy[cyc] = busy;
            lg_rdy[cyc]  = pif.pix_ready;
            lg_ld[cyc]   = latch_done;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string nm, input longint act, input longint exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic tick_to(input int c);
        while (cyc < c) tick(1);
    endtask

    task automatic push_bit(input bit b, input int t0, input int t1, input int tb);
        int th, h, l;
        th = b ? t1 : t0;
        h  = th == 0 ? 1 : th;
        l  = tb > th ? tb - th : 1;
        repeat (h) exp_q.push_back(1'b1);
        repeat (l) exp_q.push_back(1'b0);
    endtask

    task automatic push_pix(input logic [23:0] p, input int t0, input int t1, input int tb);
        for (int i = 23; i >= 0; i--) push_bit(p[i], t0, t1, tb);
    endtask

    task automatic begin_wave();
        exp_q.delete();
        exp_q.push_back(1'b0);
    endtask

    task automatic cmp_wave(input string nm, input int start);
        int mism;
        mism = 0;
        tick_to(start + exp_q.size() + 1);
        foreach (exp_q[k]) if (lg_dout[start + k] != exp_q[k]) mism++;
        check(nm, mism, 0);
    endtask

    task automatic busy_len(input int start, output int n);
        n = 0;
        while (n < 20000 && start + n < LOGN && lg_busy[start + n]) n++;
    endtask

    task automatic send(input logic [23:0] p, output int hs);
        pif.pix_valid = 1'b1;
        pif.pix_data  = p;
        for (int k = 0; k < 5000 && !pif.pix_ready; k++) tick(1);
        check("accept_ready", pif.pix_ready, 1);
        tick(1);
        hs = cyc;
        pif.pix_valid = 1'b0;
    endtask

    typedef struct {
        logic [23:0] pix;
        int t0, t1, tb;
        int total;
    } vec_t;

    initial begin
        vec_t vt [6];
        int hs, hs2, n, s, r, cnt, tot;
        logic [23:0] p;
        vt[0] = '{24'hFF0000, 26, 51, 80, 1920};
        vt[1] = '{24'h00AA55, 26, 51, 80, 1920};
        vt[2] = '{24'h800000,  0, 90, 80, 1954};
        vt[3] = '{24'h000000,  2,  5,  8,  192};
        vt[4] = '{24'hFFFFFF,  2,  5,  8,  192};
        vt[5] = '{24'h0F0F0F,  8,  8,  8,  216};
        pif.pix_valid = 1'b0;
        pif.pix_data  = '0;
        tick(3);
        check("rst_dout", dout, 0);
        check("rst_ready", pif.pix_ready, 1);
        check("rst_busy", busy, 0);
        check("rst_latch_done", latch_done, 0);
        reset = 1'b0;
        tick(2);

        for (int i = 0; i < 6; i++) begin
            t0h = CNT_W'(vt[i].t0);
            t1h = CNT_W'(vt[i].t1);
            tbit = CNT_W'(vt[i].tb);
            tick(2);
            send(vt[i].pix, hs);
            begin_wave();
            push_pix(vt[i].pix, vt[i].t0, vt[i].t1, vt[i].tb);
            cmp_wave($sformatf("wave_vec%0d", i), hs);
            tick(2);
            busy_len(hs, n);
            check($sformatf("dur_vec%0d", i), n - 1, vt[i].total);
            check($sformatf("idle_dout_vec%0d", i), dout, 0);
            check($sformatf("idle_busy_vec%0d", i), busy, 0);
        end

        t0h = 26; t1h = 51; tbit = 80; tlat = 100;
        tick(2);
        pif.pix_valid = 1'b1;
        pif.pix_data  = 24'hA5A5A5;
        tick(1);
        hs = cyc;
        pif.pix_data = 24'h3CC33C;
        for (int k = 0; k < 5000 && !pif.pix_ready; k++) tick(1);
        tick(1);
        hs2 = cyc;
        pif.pix_valid = 1'b0;
        check("b2b_accept_gap", hs2 - hs, 2);
        begin_wave();
        push_pix(24'hA5A5A5, 26, 51, 80);
        push_pix(24'h3CC33C, 26, 51, 80);
        cmp_wave("wave_b2b", hs);
        tick(2);
        busy_len(hs, n);
        check("dur_b2b", n - 1, 3840);
        check("b2b_ready_before_reload", lg_rdy[hs + 1920], 0);
        check("b2b_ready_after_reload", lg_rdy[hs + 1921], 1);

        tick(2);
        send(24'h00AA55, hs);
        tick_to(hs + 411);
        latch_req = 1'b1;
        tick(1);
        r = cyc;
        latch_req = 1'b0;
        begin_wave();
        push_pix(24'h00AA55, 26, 51, 80);
        repeat (101) exp_q.push_back(1'b0);
        cmp_wave("wave_latch", hs);
        tick_to(hs + 2100);
        cnt = 0;
        for (int k = hs; k <= hs + 2100; k++) cnt += int'(lg_ld[k]);
        check("latch_done_pulses", cnt, 1);
        check("latch_done_at", lg_ld[hs + 2021], 1);
        cnt = 0;
        for (int k = r; k <= hs + 2020; k++) cnt += int'(lg_rdy[k]);
        check("latch_ready_low", cnt, 0);
        check("latch_ready_back", lg_rdy[hs + 2021], 1);
        check("latch_busy_last", lg_busy[hs + 2020], 1);
        check("latch_busy_end", lg_busy[hs + 2021], 0);

        tlat = 0;
        tick(2);
        s = cyc;
        latch_req = 1'b1;
        tick(1);
        latch_req = 1'b0;
        tick(6);
        cnt = 0;
        for (int k = s; k <= s + 6; k++) cnt += int'(lg_ld[k]) + int'(lg_dout[k]);
        check("tlat0_pulse_count", cnt, 1);
        check("tlat0_done_at", lg_ld[s + 3], 1);
        check("tlat0_busy", lg_busy[s + 1], 1);
        tlat = 100;

        send(24'hFFFFFF, hs);
        tick_to(hs + 806);
        reset = 1'b1;
        tick(1);
        check("mid_rst_dout", dout, 0);
        check("mid_rst_ready", pif.pix_ready, 1);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_latch_done", latch_done, 0);
        reset = 1'b0;
        tick(3);
        send(24'h123456, hs);
        begin_wave();
        push_pix(24'h123456, 26, 51, 80);
        cmp_wave("wave_after_rst", hs);
        tick(2);
        busy_len(hs, n);
        check("dur_after_rst", n - 1, 1920);

        send(24'hFF0000, hs);
        tick_to(hs + 251);
        t1h = 40;
        begin_wave();
        for (int i = 0; i < 4; i++) push_bit(1'b1, 26, 51, 80);
        for (int i = 0; i < 4; i++) push_bit(1'b1, 26, 40, 80);
        for (int i = 0; i < 16; i++) push_bit(1'b0, 26, 40, 80);
        cmp_wave("wave_t1h_change", hs);
        tick(2);
        busy_len(hs, n);
        check("dur_t1h_change", n - 1, 1920);
        t1h = 51;

        for (int i = 0; i < 10; i++) begin
            t0h  = CNT_W'($urandom_range(0, 12));
            t1h  = CNT_W'($urandom_range(0, 20));
            tbit = CNT_W'($urandom_range(1, 24));
            p    = 24'($urandom);
            tick(2);
            send(p, hs);
            begin_wave();
            push_pix(p, int'(t0h), int'(t1h), int'(tbit));
            tot = exp_q.size() - 1;
            cmp_wave($sformatf("wave_rand%0d", i), hs);
            tick(2);
            busy_len(hs, n);
            check($sformatf("dur_rand%0d", i), n - 1, tot);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
